// File: rtl/counter_data_sync_filter.sv
// counter_data_sync_filter
// Multi-channel input conditioner. Every channel is an independent pipeline:
//   raw async input -> SYNC_STAGES-flop synchroniser -> stability filter
//   -> registered edge pulses -> edge counter with wrap/saturate and a
//   sticky overflow flag.
//
// Ports
//   i_clk      single clock, all state updates on its rising edge
//   i_rstn     asynchronous active-low reset, clears every flop
//   i_din      [CH]        raw asynchronous inputs, one bit per channel
//   i_cnt_clr  [CH]        per-channel synchronous clear of counter + overflow
//   o_filt     [CH]        synchronised, filtered level
//   o_rise     [CH]        one-cycle pulse when o_filt goes 0->1
//   o_fall     [CH]        one-cycle pulse when o_filt goes 1->0
//   o_cnt      [CH*CNT_W]  packed counters, channel k at [k*CNT_W +: CNT_W]
//   o_ovf      [CH]        sticky overflow, cleared by i_cnt_clr or reset
//
// Parameters
//   CH           number of channels
//   SYNC_STAGES  synchroniser depth (>= 2)
//   FILT_LEN     consecutive disagreeing synced cycles needed to flip o_filt (>= 1)
//   CNT_W        counter width (>= 1)
//   EDGE_MODE    counted edges: 0 rising, 1 falling, 2 both
//   SATURATE     0 counter wraps to 0, 1 counter holds at its maximum

module counter_data_sync_filter #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 8,
  parameter int EDGE_MODE   = 0,
  parameter int SATURATE    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [CH-1:0]         i_din,
  input  logic [CH-1:0]         i_cnt_clr,
  output logic [CH-1:0]         o_filt,
  output logic [CH-1:0]         o_rise,
  output logic [CH-1:0]         o_fall,
  output logic [CH*CNT_W-1:0]   o_cnt,
  output logic [CH-1:0]         o_ovf
);

  localparam int                FC_W    = $clog2(FILT_LEN + 1);
  localparam logic [FC_W-1:0]   FC_LAST = FC_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  // Reject configurations the datapath below cannot implement.
  generate
    if (SYNC_STAGES < 2 || FILT_LEN < 1 || CNT_W < 1 ||
        EDGE_MODE < 0 || EDGE_MODE > 2 || CH < 1) begin : g_bad_params
      $error("counter_data_sync_filter: illegal parameter set (SYNC_STAGES=%0d FILT_LEN=%0d CNT_W=%0d EDGE_MODE=%0d CH=%0d)",
             SYNC_STAGES, FILT_LEN, CNT_W, EDGE_MODE, CH);
    end
  endgenerate

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FC_W-1:0]        fc_q;
    logic                   filt_q;
    logic                   rise_q;
    logic                   fall_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ovf_q;

    logic                   s;
    logic                   flip;
    logic                   edge_hit;

    // Synchronised level seen by the filter.
    assign s = sync_q[SYNC_STAGES-1];

    // The filtered level flips on the cycle that completes a run of
    // FILT_LEN disagreeing samples; this same condition drives the pulse
    // registers and the counter so all three update on one edge.
    assign flip = (s != filt_q) && (fc_q == FC_LAST);

    assign edge_hit = (EDGE_MODE == 2) ? flip :
                      (EDGE_MODE == 1) ? (flip & ~s) :
                                         (flip &  s);

    // NOTE: all state here is written with non-blocking assignments so every
    // flop samples pre-edge values; blocking writes would let the filter see
    // this cycle's synchroniser output and shorten the chain by a stage.
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        sync_q <= '0;
        fc_q   <= '0;
        filt_q <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], i_din[k]};
        rise_q <= flip &  s;
        fall_q <= flip & ~s;
        if (s == filt_q) begin
          fc_q <= '0;
        end else if (fc_q == FC_LAST) begin
          filt_q <= s;
          fc_q   <= '0;
        end else begin
          fc_q <= fc_q + FC_W'(1);
        end
      end
    end

    // Counter and sticky overflow. A clear in the same cycle as a counted
    // edge wins and that edge is dropped.
    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (i_cnt_clr[k]) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else if (edge_hit) begin
        if (cnt_q == CNT_MAX) begin
          ovf_q <= 1'b1;
          if (SATURATE == 0) begin
            cnt_q <= '0;
          end
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign o_filt[k]                 = filt_q;
    assign o_rise[k]                 = rise_q;
    assign o_fall[k]                 = fall_q;
    assign o_ovf[k]                  = ovf_q;
    assign o_cnt[k*CNT_W +: CNT_W]   = cnt_q;
  end

endmodule

// File: tb/tb_counter_data_sync_filter.sv
// Self-checking bench for counter_data_sync_filter. Three instances share the
// same stimulus and differ only in counting configuration:
//   dut_a  defaults            (CNT_W=8, rising edges, wrap)
//   dut_b  CNT_W=4, both edges, wrap
//   dut_c  CNT_W=4, rising edges, saturate
// The reference model keeps a log of every sampled input vector and decides
// each cycle whether the filtered level flips by looking at the window of
// samples that has reached the filter through the synchroniser.

module tb_counter_data_sync_filter;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int NI   = 3;

  logic            i_clk = 1'b0;
  logic            i_rstn;
  logic [CH-1:0]   i_din;
  logic [CH-1:0]   i_cnt_clr;

  logic [CH-1:0]   a_filt, a_rise, a_fall, a_ovf;
  logic [CH*8-1:0] a_cnt;
  logic [CH-1:0]   b_filt, b_rise, b_fall, b_ovf;
  logic [CH*4-1:0] b_cnt;
  logic [CH-1:0]   c_filt, c_rise, c_fall, c_ovf;
  logic [CH*4-1:0] c_cnt;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  counter_data_sync_filter #(
    .CH(CH), .SYNC_STAGES(SYNC), .FILT_LEN(FILT),
    .CNT_W(8), .EDGE_MODE(0), .SATURATE(0)
  ) dut_a (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_din(i_din), .i_cnt_clr(i_cnt_clr),
    .o_filt(a_filt), .o_rise(a_rise), .o_fall(a_fall), .o_cnt(a_cnt), .o_ovf(a_ovf)
  );

  counter_data_sync_filter #(
    .CH(CH), .SYNC_STAGES(SYNC), .FILT_LEN(FILT),
    .CNT_W(4), .EDGE_MODE(2), .SATURATE(0)
  ) dut_b (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_din(i_din), .i_cnt_clr(i_cnt_clr),
    .o_filt(b_filt), .o_rise(b_rise), .o_fall(b_fall), .o_cnt(b_cnt), .o_ovf(b_ovf)
  );

  counter_data_sync_filter #(
    .CH(CH), .SYNC_STAGES(SYNC), .FILT_LEN(FILT),
    .CNT_W(4), .EDGE_MODE(0), .SATURATE(1)
  ) dut_c (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_din(i_din), .i_cnt_clr(i_cnt_clr),
    .o_filt(c_filt), .o_rise(c_rise), .o_fall(c_fall), .o_cnt(c_cnt), .o_ovf(c_ovf)
  );

  // ---------------- reference model ----------------
  int            cfg_w    [NI] = '{8, 4, 4};
  int            cfg_mode [NI] = '{0, 2, 0};
  int            cfg_sat  [NI] = '{0, 0, 1};

  logic [CH-1:0] samp_q[$];
  logic [CH-1:0] m_filt, m_rise, m_fall;
  int            m_cnt [NI][CH];
  bit            m_ovf [NI][CH];

  task automatic model_reset();
    samp_q.delete();
    m_filt = '0;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < NI; i++)
      for (int ch = 0; ch < CH; ch++) begin
        m_cnt[i][ch] = 0;
        m_ovf[i][ch] = 1'b0;
      end
  endtask

  // One rising clock edge with the given inputs present.
  task automatic model_edge(input logic [CH-1:0] din, input logic [CH-1:0] clr);
    int n;
    samp_q.push_back(din);
    n = samp_q.size() - 1;
    for (int ch = 0; ch < CH; ch++) begin
      bit all_differ = 1'b1;
      bit rise, fall;
      // The filter at edge n sees the raw samples taken SYNC edges earlier;
      // it flips once the last FILT of those all disagree with its level.
      for (int j = 0; j < FILT; j++) begin
        int  idx = n - SYNC - j;
        logic v  = (idx < 0) ? 1'b0 : samp_q[idx][ch];
        if (v == m_filt[ch]) all_differ = 1'b0;
      end
      rise = all_differ && !m_filt[ch];
      fall = all_differ &&  m_filt[ch];
      m_rise[ch] = rise;
      m_fall[ch] = fall;
      if (all_differ) m_filt[ch] = ~m_filt[ch];
      for (int i = 0; i < NI; i++) begin
        int  maxv = (1 << cfg_w[i]) - 1;
        bit  q    = (cfg_mode[i] == 0) ? rise :
                    (cfg_mode[i] == 1) ? fall : (rise || fall);
        if (clr[ch]) begin
          m_cnt[i][ch] = 0;
          m_ovf[i][ch] = 1'b0;
        end else if (q) begin
          if (m_cnt[i][ch] == maxv) begin
            m_ovf[i][ch] = 1'b1;
            m_cnt[i][ch] = cfg_sat[i] ? maxv : 0;
          end else begin
            m_cnt[i][ch] = m_cnt[i][ch] + 1;
          end
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    logic [CH*8-1:0] ea;
    logic [CH*4-1:0] eb, ec;
    logic [CH-1:0]   oa, ob, oc;
    for (int ch = 0; ch < CH; ch++) begin
      ea[ch*8 +: 8] = 8'(m_cnt[0][ch]);
      eb[ch*4 +: 4] = 4'(m_cnt[1][ch]);
      ec[ch*4 +: 4] = 4'(m_cnt[2][ch]);
      oa[ch]        = m_ovf[0][ch];
      ob[ch]        = m_ovf[1][ch];
      oc[ch]        = m_ovf[2][ch];
    end
    check({where, " a_filt"}, 32'(a_filt), 32'(m_filt));
    check({where, " a_rise"}, 32'(a_rise), 32'(m_rise));
    check({where, " a_fall"}, 32'(a_fall), 32'(m_fall));
    check({where, " a_rise&fall"}, 32'(a_rise & a_fall), 32'd0);
    check({where, " a_cnt"},  32'(a_cnt),  32'(ea));
    check({where, " a_ovf"},  32'(a_ovf),  32'(oa));
    check({where, " b_filt/rise/fall"}, 32'({b_filt, b_rise, b_fall}), 32'({m_filt, m_rise, m_fall}));
    check({where, " b_cnt"},  32'(b_cnt),  32'(eb));
    check({where, " b_ovf"},  32'(b_ovf),  32'(ob));
    check({where, " c_filt/rise/fall"}, 32'({c_filt, c_rise, c_fall}), 32'({m_filt, m_rise, m_fall}));
    check({where, " c_cnt"},  32'(c_cnt),  32'(ec));
    check({where, " c_ovf"},  32'(c_ovf),  32'(oc));
  endtask

  // Advance one clock: model sees the inputs present at the edge, outputs are
  // sampled 1 time unit later. Inputs are only changed after this returns.
  task automatic tick();
    @(posedge i_clk);
    model_edge(i_din, i_cnt_clr);
    #1;
    check_all("cycle");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_rstn    = 1'b0;
    i_din     = '0;
    i_cnt_clr = '0;
    model_reset();
    #12;
    check_all("reset");
    check("reset all outputs", 32'({a_filt, a_rise, a_fall, a_ovf}), 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    run(2);

    // Clean rise on ch0: new level visible 6 cycles after the sampling edge.
    i_din[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 5) check("ch0 before latency", 32'(a_filt[0]), 32'd0);
      if (i == 6) begin
        check("ch0 filt at latency", 32'(a_filt[0]), 32'd1);
        check("ch0 rise at latency", 32'(a_rise[0]), 32'd1);
        check("cnt after first rise", 32'(a_cnt), 32'h0000_0001);
      end
      if (i == 7) check("ch0 rise one cycle", 32'(a_rise[0]), 32'd0);
    end

    // ch1: 3-cycle pulse is filtered out.
    i_din[1] = 1'b1;
    run(3);
    i_din[1] = 1'b0;
    run(10);
    check("ch1 short pulse filt", 32'(a_filt[1]), 32'd0);
    check("ch1 short pulse cnt", 32'(a_cnt[15:8]), 32'd0);

    // ch1: one-cycle low glitch restarts the filter.
    i_din[1] = 1'b1;
    run(2);
    i_din[1] = 1'b0;
    run(1);
    i_din[1] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 5) check("ch1 glitch delays rise", 32'(a_filt[1]), 32'd0);
      if (i == 6) check("ch1 rise after glitch", 32'({a_filt[1], a_rise[1]}), 32'd3);
    end
    check("ch1 cnt after glitch", 32'(a_cnt[15:8]), 32'd1);

    // ch2 clean toggles: 16 edges wrap the 4-bit both-edge counter.
    for (int t = 1; t <= 40; t++) begin
      i_din[2] = ~i_din[2];
      run(6);
      if (t == 16) begin
        check("b ch2 wrap cnt", 32'(b_cnt[11:8]), 32'd0);
        check("b ch2 wrap ovf", 32'(b_ovf[2]), 32'd1);
      end
      if (t == 17) begin
        check("b ch2 post-wrap cnt", 32'(b_cnt[11:8]), 32'd1);
        check("b ch2 ovf sticky", 32'(b_ovf[2]), 32'd1);
      end
    end
    // 40 toggles = 20 rising edges on the saturating counter.
    check("c ch2 saturated cnt", 32'(c_cnt[11:8]), 32'd15);
    check("c ch2 saturated ovf", 32'(c_ovf[2]), 32'd1);
    check("a ch2 20 rises", 32'(a_cnt[23:16]), 32'd20);
    i_cnt_clr[2] = 1'b1;
    tick();
    i_cnt_clr[2] = 1'b0;
    check("c ch2 after clear", 32'({c_cnt[11:8], c_ovf[2]}), 32'd0);
    check("b ch2 after clear", 32'({b_cnt[11:8], b_ovf[2]}), 32'd0);
    run(2);

    // Clear on ch0 coincident with its rise; ch1 rise in the same cycle counts.
    i_din[0] = 1'b0;
    i_din[1] = 1'b0;
    run(8);
    i_din[0] = 1'b1;
    i_din[1] = 1'b1;
    run(5);
    i_cnt_clr[0] = 1'b1;
    tick();
    i_cnt_clr[0] = 1'b0;
    check("clr vs rise: rise[1:0]", 32'(a_rise[1:0]), 32'd3);
    check("clr vs rise: ch0 cnt", 32'(a_cnt[7:0]), 32'd0);
    check("clr vs rise: ch1 cnt", 32'(a_cnt[15:8]), 32'd2);
    run(3);
    check("ch0 cnt stays cleared", 32'(a_cnt[7:0]), 32'd0);

    // ch3: five rises, then an asynchronous reset part-way through a filter run.
    for (int t = 0; t < 10; t++) begin
      i_din[3] = ~i_din[3];
      run(6);
    end
    check("ch3 cnt before reset", 32'(a_cnt[31:24]), 32'd5);
    i_din[3] = 1'b1;
    run(3);
    #2;
    i_rstn = 1'b0;
    #1;
    model_reset();
    check_all("async reset");
    check("async reset a_cnt", 32'(a_cnt), 32'd0);
    #2;
    i_rstn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 5) check("ch3 before re-rise", 32'(a_filt[3]), 32'd0);
      if (i == 6) begin
        check("ch3 re-rise", 32'({a_filt[3], a_rise[3]}), 32'd3);
        check("ch3 cnt after re-rise", 32'(a_cnt[31:24]), 32'd1);
      end
    end

    // Randomised tail: sparse toggles (some shorter than the filter) and clears.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) i_din[$urandom_range(CH - 1)] ^= 1'b1;
      for (int ch = 0; ch < CH; ch++)
        i_cnt_clr[ch] = ($urandom_range(31) == 0);
      tick();
    end
    i_cnt_clr = '0;
    run(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
